// File: rtl/jam_pkg.sv
// Shared defaults and types for the jam cost-lookup arbiter.
package jam_pkg;

  localparam int unsigned DEF_NUM_REQ   = 4;
  localparam int unsigned DEF_BURST_LEN = 8;
  localparam int unsigned DEF_IDX_W     = 3;
  localparam int unsigned DEF_COST_W    = 7;

  // Engine that holds top priority right after reset.
  localparam int unsigned RR_FIRST = 0;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } jam_state_e;

endpackage

// File: rtl/jam_cost_arbiter_if.sv
// Engine-side request/lookup bus plus the cost-table port of the arbiter.
interface jam_cost_arbiter_if #(
  parameter int unsigned NUM_REQ = jam_pkg::DEF_NUM_REQ,
  parameter int unsigned IDX_W   = jam_pkg::DEF_IDX_W,
  parameter int unsigned COST_W  = jam_pkg::DEF_COST_W
);
  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       REQ;
  logic [NUM_REQ-1:0]       LK_VLD;
  logic [NUM_REQ*IDX_W-1:0] REQ_W;
  logic [NUM_REQ*IDX_W-1:0] REQ_J;
  logic [NUM_REQ-1:0]       GNT;
  logic [IDX_W-1:0]         W;
  logic [IDX_W-1:0]         J;
  logic [COST_W-1:0]        Cost;
  logic                     RSP_VLD;
  logic [ID_W-1:0]          RSP_ID;
  logic [COST_W-1:0]        RSP_COST;
  logic                     BUSY;

  modport master (
    output REQ, LK_VLD, REQ_W, REQ_J, Cost,
    input  GNT, W, J, RSP_VLD, RSP_ID, RSP_COST, BUSY
  );

  modport slave (
    input  REQ, LK_VLD, REQ_W, REQ_J, Cost,
    output GNT, W, J, RSP_VLD, RSP_ID, RSP_COST, BUSY
  );
endinterface

// File: rtl/jam_rr_pick.sv
// Combinational rotating-priority picker: first requester after ptr wins.
module jam_rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] win_oh,
  output logic [ID_W-1:0]    win_idx
);

  always_comb begin
    int unsigned c;
    logic        found;
    win_oh  = '0;
    win_idx = '0;
    found   = 1'b0;
    c       = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      c = 32'(ptr) + i;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (!found && req[ID_W'(c)]) begin
        found                = 1'b1;
        win_oh[ID_W'(c)]     = 1'b1;
        win_idx              = ID_W'(c);
      end
    end
  end

endmodule

// File: rtl/jam_cost_arbiter.sv
// Grants whole lookup bursts round-robin, drives the cost table and routes
// each returned cost back tagged with its requester.
module jam_cost_arbiter
  import jam_pkg::*;
#(
  parameter int unsigned NUM_REQ   = DEF_NUM_REQ,
  parameter int unsigned BURST_LEN = DEF_BURST_LEN,
  parameter int unsigned IDX_W     = DEF_IDX_W,
  parameter int unsigned COST_W    = DEF_COST_W,
  parameter int unsigned ROM_LAT   = 0
) (
  input logic               CLK,
  input logic               RST_N,
  jam_cost_arbiter_if.slave bus
);

  localparam int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W   = $clog2(BURST_LEN + 1);
  localparam int unsigned RST_PTR = (RR_FIRST + NUM_REQ - 1) % NUM_REQ;

  jam_state_e          state;
  logic [ID_W-1:0]     gidx;
  logic [ID_W-1:0]     ptr;
  logic [CNT_W-1:0]    cnt;
  logic [ROM_LAT:0]    tag_vld;
  logic [ID_W-1:0]     tag_id [ROM_LAT+1];

  logic [NUM_REQ-1:0]  pick_oh;
  logic [ID_W-1:0]     pick_idx;
  logic                keep_c;
  logic                accept_c;
  logic                last_c;
  logic [IDX_W-1:0]    sel_w_c;
  logic [IDX_W-1:0]    sel_j_c;

  jam_rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .req     (bus.REQ),
    .ptr     (ptr),
    .win_oh  (pick_oh),
    .win_idx (pick_idx)
  );

  assign keep_c   = bus.REQ[gidx];
  assign accept_c = bus.GNT[gidx] && bus.REQ[gidx] && bus.LK_VLD[gidx];
  assign last_c   = (cnt == CNT_W'(BURST_LEN - 1));
  assign sel_w_c  = bus.REQ_W[gidx*IDX_W +: IDX_W];
  assign sel_j_c  = bus.REQ_J[gidx*IDX_W +: IDX_W];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= IDLE;
      gidx         <= '0;
      ptr          <= ID_W'(RST_PTR);
      cnt          <= '0;
      tag_vld      <= '0;
      for (int i = 0; i <= int'(ROM_LAT); i++) tag_id[i] <= '0;
      bus.GNT      <= '0;
      bus.W        <= '0;
      bus.J        <= '0;
      bus.RSP_VLD  <= 1'b0;
      bus.RSP_ID   <= '0;
      bus.RSP_COST <= '0;
      bus.BUSY     <= 1'b0;
    end else begin
      // Tag pipeline tracks which engine owns the cost arriving ROM_LAT+1 edges later.
      tag_vld[0] <= accept_c;
      tag_id[0]  <= gidx;
      for (int i = 1; i <= int'(ROM_LAT); i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_id[i]  <= tag_id[i-1];
      end

      bus.RSP_VLD <= tag_vld[ROM_LAT];
      if (tag_vld[ROM_LAT]) begin
        bus.RSP_ID   <= tag_id[ROM_LAT];
        bus.RSP_COST <= bus.Cost;
      end
      bus.BUSY <= (state == GRANT) || (|tag_vld);

      unique case (state)
        IDLE: begin
          if (|bus.REQ) begin
            state   <= GRANT;
            bus.GNT <= pick_oh;
            gidx    <= pick_idx;
            cnt     <= '0;
          end
        end
        GRANT: begin
          if (!keep_c) begin
            state   <= IDLE;
            bus.GNT <= '0;
            ptr     <= gidx;
          end else if (accept_c) begin
            bus.W <= sel_w_c;
            bus.J <= sel_j_c;
            cnt   <= cnt + CNT_W'(1);
            if (last_c) begin
              state   <= IDLE;
              bus.GNT <= '0;
              ptr     <= gidx;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/jam_cost_arbiter.md
Name: jam_cost_arbiter

Overview:
- Shares one worker/job cost lookup port (W, J in; Cost back) among NUM_REQ assignment-search engines.
- Each engine evaluates one permutation as a burst of BURST_LEN lookups. The arbiter grants whole bursts round-robin, drives the lookup port, and routes each returned Cost back with the requester ID.
- Sits between the search engines and the cost table.

Parameters:
NUM_REQ, 4, number of requesting engines (2..8)
BURST_LEN, 8, lookups per granted burst (one permutation)
IDX_W, 3, width of W and J indices
COST_W, 7, width of Cost
ROM_LAT, 0, cycles from W/J valid until Cost valid (0..3; 0 = Cost valid in the same cycle W/J change)

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous reset, active-low
REQ  in  NUM_REQ  per-engine burst request, held high for the whole burst
LK_VLD  in  NUM_REQ  per-engine lookup valid, meaningful only while granted
REQ_W  in  NUM_REQ*IDX_W  per-engine worker index, slice k belongs to engine k
REQ_J  in  NUM_REQ*IDX_W  per-engine job index
GNT  out  NUM_REQ  one-hot grant, registered
W  out  IDX_W  worker index to cost table, registered
J  out  IDX_W  job index to cost table, registered
Cost  in  COST_W  cost table data
RSP_VLD  out  1  response strobe, one cycle per lookup
RSP_ID  out  clog2(NUM_REQ)  engine the response belongs to
RSP_COST  out  COST_W  returned cost
BUSY  out  1  grant active or any lookup in flight

Behaviour:
- Reset (RST_N low, takes effect immediately): GNT=0, W=0, J=0, RSP_VLD=0, RSP_ID=0, RSP_COST=0, BUSY=0, state=IDLE, burst counter=0.
  - Round-robin pointer resets so that engine 0 has top priority.
  - The tag pipeline is cleared, so in-flight lookups are dropped.
- States: IDLE, GRANT.
- IDLE behaviour:
  - If any REQ is high at an edge, the first requester in rotating order after the last-granted engine wins.
  - GNT[k] is high from that edge; state moves to GRANT and the counter is cleared.
  - With no REQ, IDLE holds.
- GRANT behaviour:
  - A lookup is accepted at an edge when GNT[k] & REQ[k] & LK_VLD[k] are all high.
  - On acceptance: W <= REQ_W slice k, J <= REQ_J slice k, counter +1, and tag k is pushed into a depth-(ROM_LAT+1) valid/ID shift pipeline.
  - Throughput is one lookup per cycle. LK_VLD low inserts a gap without ending the burst.
  - W and J hold their last value when no lookup is accepted.
- Burst end:
  - The burst ends at the edge that accepts lookup number BURST_LEN. At that edge GNT goes to 0, state goes to IDLE, and the pointer is set to k.
  - This gives a mandatory one-cycle grant gap between consecutive bursts, including back-to-back bursts by the same engine.
- Abort:
  - If REQ[k] is low at an edge while in GRANT, no lookup is accepted, GNT goes to 0, state goes to IDLE, and the pointer is set to k.
  - Lookups already accepted still return.
- Response timing:
  - For a lookup accepted at edge e, Cost is sampled at edge e+1+ROM_LAT.
  - RSP_VLD=1, RSP_ID=k and RSP_COST=Cost are visible for exactly one cycle after that edge.
  - Responses come back in acceptance order and are never lost or duplicated.
  - Responses may overlap the next engine's grant.
- RSP_COST holds its value when RSP_VLD=0.
- BUSY = (state==GRANT) | any pipeline valid bit, registered.
- Simultaneous events:
  - If REQ drops on the same edge that would accept the last lookup, abort wins and that lookup is not accepted.
  - Requests arriving during GRANT wait; there is no preemption.
- Counter is clog2(BURST_LEN+1) bits wide and never wraps within a burst.

Decomposition:
- Shared package jam_pkg holds: IDX_W, COST_W, BURST_LEN defaults, the state enum {IDLE, GRANT}, and a rotating-priority helper constant.
- One sub-module: jam_rr_pick, a combinational rotating-priority picker. Inputs are REQ and the pointer; outputs are a one-hot winner and its index.
- The tag pipeline stays inline.

Test Plan:
1. Single requester, continuous lookups:
   - Stimulus: from reset, REQ[0]=1 with LK_VLD[0]=1 continuously; REQ_W=0..7, REQ_J=7-W; cost model returns W*8+J.
   - Required: GNT[0] high for exactly 8 acceptance cycles. W/J follow 0/7, 1/6, … 7/0. Eight responses with RSP_ID=0 and costs 7, 14, … 56. GNT=0 after the 8th acceptance.
2. All four requesting from reset:
   - Stimulus: REQ=4'b1111 held.
   - Required: grant order 0, 1, 2, 3, 0. Each burst is 8 lookups. GNT=0 for exactly one cycle between bursts.
3. Lookup gaps:
   - Stimulus: engine 2 alone, LK_VLD[2] toggling every cycle.
   - Required: grant lasts 16 cycles with exactly 8 RSP_VLD pulses, all with RSP_ID=2.
4. Abort mid-burst:
   - Stimulus: engines 1 and 2 requesting; engine 1 drops REQ after 3 accepted lookups.
   - Required: GNT[1] drops at that edge. Exactly 3 responses with RSP_ID=1. The next grant goes to engine 2 after a one-cycle gap.
5. ROM_LAT=2 instance:
   - Stimulus: cost model delays W*8+J by 2 cycles; engine 3 runs a full burst.
   - Required: each response appears 3 cycles after its accepting edge with the correct cost. BUSY stays high until the final response clears.
6. Reset mid-burst:
   - Stimulus: RST_N pulsed low while 2 lookups are in flight during engine 1's burst.
   - Required: all outputs are 0 immediately. No RSP_VLD after release. With REQ=4'b1010 after release, the first grant is GNT[1].
